// File: rtl/d_debounce.sv
// Input conditioner: synchronises a raw asynchronous level, debounces it with a
// counter FSM and presents a clean registered level with rise/fall event pulses.
module d_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic sample_en,
  output logic q,
  output logic rise,
  output logic fall,
  output logic stable
);

  typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam bit               ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_s;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic             q_n, rise_n, fall_n, stable_n;

  // Synchroniser shifts every clock regardless of the sample qualifier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign d_s     = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    q_n     = q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    if (sample_en) begin
      case (state_q)
        STABLE_LO: begin
          if (d_s) begin
            if (ONE_SHOT) begin
              state_n = STABLE_HI;
              q_n     = 1'b1;
              rise_n  = 1'b1;
            end else begin
              state_n = CHK_HI;
              cnt_n   = CNT_W'(1);
            end
          end
        end
        CHK_HI: begin
          if (!d_s) begin
            state_n = STABLE_LO;
            cnt_n   = '0;
          end else if (cnt_inc == CNT_LAST) begin
            state_n = STABLE_HI;
            cnt_n   = '0;
            q_n     = 1'b1;
            rise_n  = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        STABLE_HI: begin
          if (!d_s) begin
            if (ONE_SHOT) begin
              state_n = STABLE_LO;
              q_n     = 1'b0;
              fall_n  = 1'b1;
            end else begin
              state_n = CHK_LO;
              cnt_n   = CNT_W'(1);
            end
          end
        end
        CHK_LO: begin
          if (d_s) begin
            state_n = STABLE_HI;
            cnt_n   = '0;
          end else if (cnt_inc == CNT_LAST) begin
            state_n = STABLE_LO;
            cnt_n   = '0;
            q_n     = 1'b0;
            fall_n  = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = STABLE_LO;
          cnt_n   = '0;
        end
      endcase
    end
    stable_n = (state_n == STABLE_LO) || (state_n == STABLE_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      q       <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      stable  <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      q       <= q_n;
      rise    <= rise_n;
      fall    <= fall_n;
      stable  <= stable_n;
    end
  end

endmodule
